// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : skid-mode selectors and control-bit positions shared by stages
// Rev 1.0
// ============================================================================
package pipe_pkg;

   localparam int SKID_NONE   = 0;
   localparam int SKID_TWO    = 1;

   // Bit positions inside the per-stage ctrl vector
   localparam int REGWRITE    = 0;
   localparam int MEMWRITE    = 1;
   localparam int RESULTSRC   = 2;
   localparam int RESULTSRC_W = 2;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_entry_reg.sv
`default_nettype none
// ============================================================================
// pipe_entry_reg : valid+ctrl+data holding register with load enable and kill
// Rev 1.0
// ============================================================================
module pipe_entry_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_kill,
   input  logic              i_valid,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [DATA_W-1:0] o_data
);

   logic              r_valid;
   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_data;

   // Kill clears valid/ctrl only; the payload is left alone so a bubble keeps
   // the last data and never commits because its ctrl is zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_data  <= '0;
      end else if (i_kill) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
      end else if (i_load) begin
         r_valid <= i_valid;
         r_ctrl  <= i_valid ? i_ctrl : '0;
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_ctrl  = r_ctrl;
   assign o_data  = r_data;

endmodule : pipe_entry_reg
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg : valid/ready pipeline register with flush, optional skid
//                  entry and saturating stall counter
// Rev 1.0
// ============================================================================
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic              w_accept;
   logic              w_main_free;
   logic              w_main_valid_d;
   logic [CTRL_W-1:0] w_main_ctrl_d;
   logic [DATA_W-1:0] w_main_data_d;
   logic              r_skid_valid;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic [DATA_W-1:0] r_skid_data;
   logic [CNT_W-1:0]  r_stall_cnt;

   assign w_accept    = in_valid & in_ready;
   assign w_main_free = !out_valid | out_ready;

   // A waiting skid entry is always older than the current input beat.
   assign w_main_valid_d = r_skid_valid | w_accept;
   assign w_main_ctrl_d  = r_skid_valid ? r_skid_ctrl : in_ctrl;
   assign w_main_data_d  = r_skid_valid ? r_skid_data : in_data;

   pipe_entry_reg #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_main_free),
      .i_kill  (flush),
      .i_valid (w_main_valid_d),
      .i_ctrl  (w_main_ctrl_d),
      .i_data  (w_main_data_d),
      .o_valid (out_valid),
      .o_ctrl  (out_ctrl),
      .o_data  (out_data)
   );

   generate
      if (SKID != SKID_NONE) begin : g_skid
         logic w_skid_load;

         // Refill when draining into main, or catch a beat while main is stuck
         assign w_skid_load = w_main_free ? r_skid_valid : w_accept;
         assign in_ready    = !r_skid_valid;

         pipe_entry_reg #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
         ) u_skid (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_skid_load),
            .i_kill  (flush),
            .i_valid (w_accept),
            .i_ctrl  (in_ctrl),
            .i_data  (in_data),
            .o_valid (r_skid_valid),
            .o_ctrl  (r_skid_ctrl),
            .o_data  (r_skid_data)
         );
      end else begin : g_no_skid
         assign r_skid_valid = 1'b0;
         assign r_skid_ctrl  = '0;
         assign r_skid_data  = '0;
         assign in_ready     = w_main_free;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (out_valid && !out_ready && (r_stall_cnt != c_cnt_max)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;

endmodule : pipe_stage_reg
`default_nettype wire
